// File: rtl/z80_io_tx_fifo_if.sv
// Z80 I/O bus and per-channel transmit byte streams for z80_io_tx_fifo.
// The peripheral connects through the slave modport and the CPU/consumer side through master.
interface z80_io_tx_fifo_if #(
    parameter int NUM_CH = 2
);
    logic                  iorq_n;
    logic                  m1_n;
    logic                  rd_n;
    logic                  wr_n;
    logic [7:0]            addr;
    logic [7:0]            cpu_do;
    logic [7:0]            io_di;
    logic                  io_sel;
    logic [NUM_CH-1:0]     tx_valid;
    logic [8*NUM_CH-1:0]   tx_data;
    logic [NUM_CH-1:0]     tx_ready;

    modport master (
        output iorq_n, m1_n, rd_n, wr_n,
        output addr, cpu_do, tx_ready,
        input  io_di, io_sel,
        input  tx_valid, tx_data
    );

    modport slave (
        input  iorq_n, m1_n, rd_n, wr_n,
        input  addr, cpu_do, tx_ready,
        output io_di, io_sel,
        output tx_valid, tx_data
    );
endinterface

// File: rtl/z80_io_tx_fifo.sv
// I/O-mapped multi-channel transmit FIFO for the tv80s bus.
// OUT pushes bytes, the status port reports full/overflow and takes flush/clear.
module z80_io_tx_fifo #(
    parameter int         NUM_CH    = 2,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] BASE_PORT = 8'h10
) (
    input  logic               clk,
    input  logic               reset_n,
    z80_io_tx_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic              wr_act;
    logic              rd_act;
    logic              wr_prev;
    logic              wr_evt;
    logic              st_hit;
    logic [NUM_CH-1:0] dat_hit;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] ovf;
    logic [7:0]        sat [NUM_CH];
    logic [7:0]        io_di;
    logic              io_sel;

    assign wr_act = ~bus.iorq_n & ~bus.wr_n & bus.m1_n;
    assign rd_act = ~bus.iorq_n & ~bus.rd_n & bus.m1_n;
    assign st_hit = bus.addr == (BASE_PORT + 8'd4);

    // An OUT cycle spans several clocks; only its first edge is an event.
    assign wr_evt = wr_act & ~wr_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= wr_act;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [7:0] PORT = BASE_PORT + 8'(c);

        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [CW-1:0] cnt;
        logic [8:0]    cnt9;
        logic          ovf_r;
        logic          push;
        logic          flush;
        logic          clr;
        logic          pop;
        logic          take;

        assign dat_hit[c] = bus.addr == PORT;
        assign push  = wr_evt & dat_hit[c];
        assign flush = wr_evt & st_hit & bus.cpu_do[c];
        assign clr   = wr_evt & st_hit & bus.cpu_do[4+c];
        assign full[c] = cnt == CW'(DEPTH);
        assign pop   = (cnt != '0) & bus.tx_ready[c];
        // A pop on a full FIFO frees the slot for a push on the same edge.
        assign take  = push & ~flush & (~full[c] | pop);

        always_ff @(posedge clk) begin
            if (take) begin
                mem[wptr] <= bus.cpu_do;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr  <= '0;
                rptr  <= '0;
                cnt   <= '0;
                ovf_r <= 1'b0;
            end else begin
                if (flush) begin
                    wptr <= '0;
                    rptr <= '0;
                    cnt  <= '0;
                end else begin
                    if (take) wptr <= wptr + 1'b1;
                    if (pop)  rptr <= rptr + 1'b1;
                    cnt <= cnt + CW'(take) - CW'(pop);
                end
                if (clr) begin
                    ovf_r <= 1'b0;
                end else if (push & ~flush & ~take) begin
                    ovf_r <= 1'b1;
                end
            end
        end

        assign cnt9   = 9'(cnt);
        assign sat[c] = cnt9[8] ? 8'hFF : cnt9[7:0];
        assign ovf[c] = ovf_r;
        assign bus.tx_valid[c] = cnt != '0;
        assign bus.tx_data[8*c +: 8] = mem[rptr];
    end

    always_comb begin
        io_sel = 1'b0;
        io_di  = 8'h00;
        if (rd_act) begin
            if (st_hit) begin
                io_sel = 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    io_di[c]   = full[c];
                    io_di[4+c] = ovf[c];
                end
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (dat_hit[c]) begin
                        io_sel = 1'b1;
                        io_di  = sat[c];
                    end
                end
            end
        end
    end

    assign bus.io_di  = io_di;
    assign bus.io_sel = io_sel;
endmodule
